// File: rtl/receptor_trama_ps2.sv
// PS/2 frame receiver: synchronises and de-glitches ps2c, shifts in 11-bit frames
// on filtered falling edges, and reports good/bad frames with registered ticks.
module receptor_trama_ps2 #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk_nexys,
  input  logic       reset,
  input  logic       rx_en,
  input  logic       ps2c,
  input  logic       ps2d,
  output logic [7:0] dato,
  output logic       rx_done_tick,
  output logic       rx_err_tick,
  output logic [2:0] err_code,
  output logic [7:0] err_cnt
);

  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYC - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RECV  = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;

  logic                  ps2c_s1_q, ps2c_s2_q;
  logic                  ps2d_s1_q, ps2d_s2_q;
  logic [FILTER_LEN-1:0] filt_q, filt_d;
  logic                  fclk_q, fclk_d;
  logic                  fall_edge;

  logic [1:0]    state_q, state_d;
  logic [10:0]   shreg_q, shreg_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic [TW-1:0] to_q, to_d;

  logic [7:0] dato_q, dato_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic [2:0] err_code_q, err_code_d;
  logic [7:0] err_cnt_q, err_cnt_d;

  logic framing_bad, parity_bad;

  // Filtered clock only moves once the whole window agrees, so short glitches never toggle it.
  always_comb begin
    filt_d = {ps2c_s2_q, filt_q[FILTER_LEN-1:1]};
    fclk_d = fclk_q;
    if (&filt_q) begin
      fclk_d = 1'b1;
    end else if (~|filt_q) begin
      fclk_d = 1'b0;
    end
  end

  assign fall_edge   = fclk_q & ~fclk_d;
  assign framing_bad = shreg_q[0] | ~shreg_q[10];
  assign parity_bad  = ~(^shreg_q[9:1]);

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bitcnt_d   = bitcnt_q;
    to_d       = to_q;
    dato_d     = dato_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    err_cnt_d  = err_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (fall_edge && rx_en) begin
          shreg_d  = {ps2d_s2_q, shreg_q[10:1]};
          bitcnt_d = 4'd9;
          to_d     = '0;
          state_d  = S_RECV;
        end
      end

      S_RECV: begin
        // A fall_edge in the timeout cycle takes priority, so it is tested first.
        if (fall_edge) begin
          shreg_d = {ps2d_s2_q, shreg_q[10:1]};
          to_d    = '0;
          if (bitcnt_q == 4'd0) begin
            state_d = S_CHECK;
          end else begin
            bitcnt_d = bitcnt_q - 4'd1;
          end
        end else if (to_q == TO_MAX) begin
          err_d      = 1'b1;
          err_code_d = 3'b100;
          if (err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
          state_d = S_IDLE;
        end else begin
          to_d = to_q + TW'(1);
        end
      end

      S_CHECK: begin
        state_d = S_IDLE;
        if (!framing_bad && !parity_bad) begin
          done_d     = 1'b1;
          dato_d     = shreg_q[8:1];
          err_code_d = 3'b000;
        end else begin
          err_d      = 1'b1;
          err_code_d = {1'b0, parity_bad, framing_bad};
          if (err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_nexys) begin
    if (reset) begin
      ps2c_s1_q  <= 1'b1;
      ps2c_s2_q  <= 1'b1;
      ps2d_s1_q  <= 1'b1;
      ps2d_s2_q  <= 1'b1;
      filt_q     <= '1;
      fclk_q     <= 1'b1;
      state_q    <= S_IDLE;
      shreg_q    <= '0;
      bitcnt_q   <= '0;
      to_q       <= '0;
      dato_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      ps2c_s1_q  <= ps2c;
      ps2c_s2_q  <= ps2c_s1_q;
      ps2d_s1_q  <= ps2d;
      ps2d_s2_q  <= ps2d_s1_q;
      filt_q     <= filt_d;
      fclk_q     <= fclk_d;
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bitcnt_q   <= bitcnt_d;
      to_q       <= to_d;
      dato_q     <= dato_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign dato         = dato_q;
  assign rx_done_tick = done_q;
  assign rx_err_tick  = err_q;
  assign err_code     = err_code_q;
  assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_receptor_trama_ps2.sv
// Directed + randomized bench for receptor_trama_ps2; expected results come from
// a frame-level model (parity/framing rules, saturating error count).
`timescale 1ns/1ps
module tb_receptor_trama_ps2;

  localparam int FL = 8;
  localparam int TO = 50;
  localparam int LO = 10;
  localparam int HI = 10;

  logic       clk_nexys = 1'b0;
  logic       reset = 1'b1;
  logic       rx_en = 1'b1;
  logic       ps2c = 1'b1;
  logic       ps2d = 1'b1;
  logic [7:0] dato;
  logic       rx_done_tick;
  logic       rx_err_tick;
  logic [2:0] err_code;
  logic [7:0] err_cnt;

  receptor_trama_ps2 #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
    .clk_nexys    (clk_nexys),
    .reset        (reset),
    .rx_en        (rx_en),
    .ps2c         (ps2c),
    .ps2d         (ps2d),
    .dato         (dato),
    .rx_done_tick (rx_done_tick),
    .rx_err_tick  (rx_err_tick),
    .err_code     (err_code),
    .err_cnt      (err_cnt)
  );

  always #5 clk_nexys = ~clk_nexys;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_seen = 0;
  int err_seen = 0;
  int both_seen = 0;
  int tick_cyc = 0;
  int fall_cyc = 0;

  logic [7:0] exp_dato = 8'h00;
  logic [2:0] exp_code = 3'b000;
  int         exp_cnt = 0;

  always @(posedge clk_nexys) cyc <= cyc + 1;

  always @(negedge clk_nexys) begin
    if (rx_done_tick) begin
      done_seen <= done_seen + 1;
      tick_cyc  <= cyc;
    end
    if (rx_err_tick) begin
      err_seen <= err_seen + 1;
      tick_cyc <= cyc;
    end
    if (rx_done_tick && rx_err_tick) both_seen <= both_seen + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_nexys);
  endtask

  // One PS/2 bit: data settles, ps2c low then high; optional sub-filter glitch afterwards.
  task automatic send_bit(input logic b, input logic glitch);
    ps2d = b;
    wait_cyc(2);
    ps2c = 1'b0;
    fall_cyc = cyc;
    wait_cyc(LO);
    ps2c = 1'b1;
    wait_cyc(HI);
    if (glitch) begin
      ps2c = 1'b0;
      wait_cyc(FL - 1);
      ps2c = 1'b1;
      wait_cyc(HI);
    end
  endtask

  task automatic run_frame(input string tag, input logic [7:0] data, input logic par_flip,
                           input logic start_b, input logic stop_b, input logic glitch,
                           input logic drop_en);
    logic [10:0] bits;
    logic        par;
    logic        good;
    int d0, e0;
    par  = (~^data) ^ par_flip;
    bits = {stop_b, par, data, start_b};
    d0 = done_seen;
    e0 = err_seen;
    for (int i = 0; i < 11; i++) begin
      send_bit(bits[i], glitch && (i == 5));
      if (drop_en && i == 0) rx_en = 1'b0;
    end
    rx_en = 1'b1;
    wait_cyc(4);
    good = !start_b && stop_b && (^{par, data});
    if (good) begin
      exp_dato = data;
      exp_code = 3'b000;
    end else begin
      exp_code = {1'b0, ~(^{par, data}), start_b | ~stop_b};
      if (exp_cnt < 255) exp_cnt++;
    end
    check({tag, " done_ticks"}, done_seen - d0, good ? 1 : 0);
    check({tag, " err_ticks"}, err_seen - e0, good ? 0 : 1);
    check({tag, " latency"}, tick_cyc - fall_cyc, FL + 4);
    check({tag, " dato"}, dato, exp_dato);
    check({tag, " err_code"}, err_code, exp_code);
    check({tag, " err_cnt"}, err_cnt, exp_cnt);
    $display("frame %s data=%02h bits=%03h good=%0d dato=%02h err_code=%03b err_cnt=%0d",
             tag, data, bits, good, dato, err_code, err_cnt);
  endtask

  initial begin
    int d0, e0, f5;
    logic [7:0] rd;
    logic rs, rp, rstop;

    wait_cyc(5);
    check("reset dato", dato, 8'h00);
    check("reset err_code", err_code, 3'b000);
    check("reset err_cnt", err_cnt, 8'h00);
    check("reset ticks", {rx_done_tick, rx_err_tick}, 2'b00);
    reset = 1'b0;
    wait_cyc(20);

    run_frame("good_1C", 8'h1C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_frame("par_1C", 8'h1C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    run_frame("framing", 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_frame("framing_par", 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    run_frame("good_after_err", 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    for (int k = 0; k < 12; k++) begin
      rd    = 8'($urandom);
      rp    = ($urandom_range(0, 3) == 0);
      rs    = ($urandom_range(0, 5) == 0);
      rstop = ($urandom_range(0, 5) != 0);
      run_frame("random", rd, rp, rs, rstop, 1'b0, ($urandom_range(0, 1) == 1));
    end

    // Timeout: five edges, then ps2c stays high.
    d0 = done_seen;
    e0 = err_seen;
    for (int i = 0; i < 5; i++) send_bit(1'b0, 1'b0);
    f5 = fall_cyc;
    wait_cyc(80);
    if (exp_cnt < 255) exp_cnt++;
    exp_code = 3'b100;
    check("timeout err_ticks", err_seen - e0, 1);
    check("timeout done_ticks", done_seen - d0, 0);
    check("timeout latency", tick_cyc - f5, FL + 2 + TO + 1);
    check("timeout err_code", err_code, exp_code);
    check("timeout err_cnt", err_cnt, exp_cnt);
    check("timeout dato", dato, exp_dato);
    $display("timeout err_code=%03b err_cnt=%0d", err_code, err_cnt);
    run_frame("after_timeout_F0", 8'hF0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Sub-filter glitches while idle must not start a frame.
    d0 = done_seen;
    e0 = err_seen;
    for (int i = 0; i < 3; i++) begin
      ps2c = 1'b0;
      wait_cyc(FL - 1);
      ps2c = 1'b1;
      wait_cyc(HI);
    end
    wait_cyc(80);
    check("glitch_idle ticks", (done_seen - d0) + (err_seen - e0), 0);
    $display("glitch_idle ticks=%0d", (done_seen - d0) + (err_seen - e0));
    run_frame("glitch_mid", 8'h6B, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    // rx_en low at the start edge: whole frame ignored.
    rx_en = 1'b0;
    d0 = done_seen;
    e0 = err_seen;
    for (int i = 0; i < 11; i++) send_bit(i[0], 1'b0);
    wait_cyc(10);
    check("rx_en_off ticks", (done_seen - d0) + (err_seen - e0), 0);
    check("rx_en_off dato", dato, exp_dato);
    $display("rx_en_off ticks=%0d dato=%02h", (done_seen - d0) + (err_seen - e0), dato);
    rx_en = 1'b1;
    wait_cyc(80);
    run_frame("after_en", 8'h81, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Reset after bit 4 discards the partial frame.
    d0 = done_seen;
    e0 = err_seen;
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    reset = 1'b1;
    wait_cyc(3);
    check("midreset dato", dato, 8'h00);
    check("midreset err_code", err_code, 3'b000);
    check("midreset err_cnt", err_cnt, 8'h00);
    check("midreset ticks", {rx_done_tick, rx_err_tick}, 2'b00);
    reset = 1'b0;
    exp_dato = 8'h00;
    exp_code = 3'b000;
    exp_cnt  = 0;
    wait_cyc(80);
    check("midreset no_tick", (done_seen - d0) + (err_seen - e0), 0);
    $display("midreset dato=%02h err_code=%03b err_cnt=%0d", dato, err_code, err_cnt);
    run_frame("after_reset", 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Saturation of the bad-frame counter.
    for (int k = 0; k < 257; k++) begin
      run_frame("sat", 8'(k), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    check("sat err_cnt_final", err_cnt, 8'hFF);

    check("never_both_ticks", both_seen, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/receptor_trama_ps2.md
RECEPTOR_TRAMA_PS2 -- requirements
Module: receptor_trama_ps2

Interface
REQ-001 The block SHALL have parameter FILTER_LEN, default 8: ps2c glitch-filter depth in clk_nexys cycles, allowed range 2..16.
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 100000: idle clk_nexys cycles allowed between ps2c falling edges inside a frame, allowed range >= 2.
REQ-003 The block SHALL have port clk_nexys, input, 1 bit: the only clock; all flops are on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port rx_en, input, 1 bit: start of a new frame is accepted only while high.
REQ-006 The block SHALL have ports ps2c and ps2d, inputs, 1 bit each: raw, asynchronous PS/2 clock and data.
REQ-007 The block SHALL have port dato, output, 8 bits: last correctly received data byte.
REQ-008 The block SHALL have port rx_done_tick, output, 1 bit: one-cycle pulse for a good frame.
REQ-009 The block SHALL have port rx_err_tick, output, 1 bit: one-cycle pulse for a bad frame.
REQ-010 The block SHALL have port err_code, output, 3 bits: bit0 framing (start or stop bit), bit1 parity, bit2 timeout.
REQ-011 The block SHALL have port err_cnt, output, 8 bits: count of bad frames, saturating.

Function
REQ-012 ps2c and ps2d SHALL each pass through a 2-flop synchroniser before any other use.
REQ-013 The synchronised ps2c SHALL shift into a FILTER_LEN-bit register; filtered clock goes to 1 when the register is all ones, to 0 when it is all zeros, and holds otherwise.
REQ-014 fall_edge SHALL be high for one cycle when the filtered clock is 1 and its next value is 0.
REQ-015 The FSM SHALL have three states: IDLE, RECV and CHECK.
REQ-016 IDLE: on fall_edge with rx_en=1, the FSM SHALL shift in synchronised ps2d, load the bit counter with 9, clear the timeout counter and go to RECV; on fall_edge with rx_en=0 it SHALL do nothing.
REQ-017 RECV: on each fall_edge the FSM SHALL shift ps2d into an 11-bit register (LSB first); when the counter is 0 it goes to CHECK, otherwise it decrements the counter; rx_en is ignored in RECV.
REQ-018 Frame layout SHALL be: b[0] start, b[8:1] data LSB first, b[9] odd parity, b[10] stop.
REQ-019 RECV timeout: the timeout counter SHALL clear on every fall_edge and increment otherwise; when it reaches TIMEOUT_CYC-1 without a fall_edge, err_code SHALL be set to 3'b100, an error is flagged, and the FSM returns to IDLE.
REQ-020 If fall_edge and timeout occur in the same cycle, fall_edge SHALL win and no timeout is flagged.
REQ-021 CHECK lasts one cycle, then goes to IDLE. A frame is good only if b[0]=0, b[10]=1 and b[9:1] has an odd number of ones; otherwise bit0 and/or bit1 of err_code is set per failing check, and both may be set together.
REQ-022 Outputs SHALL be registered: if fall_edge of bit 11 occurs in cycle N, CHECK is cycle N+1 and rx_done_tick or rx_err_tick is high in cycle N+2 only.
REQ-023 Good frame: dato SHALL be loaded with b[8:1] in the same cycle rx_done_tick is high, and err_code SHALL become 0.
REQ-024 Bad frame or timeout: dato SHALL hold its value, err_code holds until the next frame result, and err_cnt increments, saturating at 255.
REQ-025 rx_done_tick and rx_err_tick SHALL never be high in the same cycle.

Reset
REQ-026 While reset is high: state goes to IDLE; the shift register, bit counter and timeout counter clear; the synchronisers, filter register and filtered clock set to 1; dato=0, err_code=0, err_cnt=0, and both ticks are 0.
REQ-027 Reset mid-frame SHALL discard the partial frame with no tick; the first frame after reset is received normally.

Verification
REQ-028 Frame 0x1C with parity=0 and stop=1, FILTER_LEN=8 -> one rx_done_tick two cycles after the 11th edge; dato=8'h1C; err_code=0.
REQ-029 Frame 0x1C with parity=1 -> rx_err_tick; err_code=3'b010; dato unchanged; err_cnt increments by 1.
REQ-030 Start bit=1 and stop bit=0 with correct parity -> rx_err_tick with err_code=3'b001; parity also wrong -> err_code=3'b011.
REQ-031 TIMEOUT_CYC=50; stop ps2c after 5 edges -> rx_err_tick with err_code=3'b100 after 50 idle cycles; the next full frame 0xF0 is received correctly.
REQ-032 ps2c glitches of FILTER_LEN-1 cycles -> no fall_edge and no bit shifted; rx_en=0 at a start edge -> frame ignored; reset asserted after bit 4 -> no tick, and all outputs show their reset values.
REQ-033 256 consecutive bad frames -> err_cnt=255 and held at 255.
